// File: rtl/tlb_pkg.sv
// tlb_pkg
//   Shared encodings for the TLB maintenance controller: operation codes,
//   INVTLB sub-operations, controller states, LFSR constants and the bit
//   positions of the TLB-related CSR fields. Also holds a helper that packs
//   one page half of a TLB entry into TLBELO layout.
//   Imported by tlb_wb_ctrl and tlb_inv_match.

package tlb_pkg;

   typedef enum logic [2:0] {
      OP_NOP  = 3'd0,
      OP_SRCH = 3'd1,
      OP_RD   = 3'd2,
      OP_WR   = 3'd3,
      OP_FILL = 3'd4,
      OP_INV  = 3'd5
   } tlbOpE;

   localparam logic [4:0] INV_ALL0       = 5'd0;
   localparam logic [4:0] INV_ALL1       = 5'd1;
   localparam logic [4:0] INV_G1         = 5'd2;
   localparam logic [4:0] INV_G0         = 5'd3;
   localparam logic [4:0] INV_G0_ASID    = 5'd4;
   localparam logic [4:0] INV_G0_ASID_VA = 5'd5;
   localparam logic [4:0] INV_GASID_VA   = 5'd6;
   localparam logic [4:0] INV_OP_MAX     = 5'd6;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      EXEC  = 2'd1,
      SWEEP = 2'd2
   } ctrlStateE;

   // Fibonacci LFSR, taps 16,14,13,11 expressed as bit mask (bit n-1)
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // TLB refill exception code: WR/FILL always write a valid entry then
   localparam logic [5:0] ECODE_TLBR = 6'h3f;

   localparam int TLBIDX_NE    = 31;
   localparam int TLBIDX_PS_HI = 29;
   localparam int TLBIDX_PS_LO = 24;
   localparam int EHI_VPPN_LO  = 13;
   localparam int ELO_G        = 6;
   localparam int ELO_PPN_HI   = 27;
   localparam int ELO_PPN_LO   = 8;
   localparam logic [5:0] PS_HUGE = 6'd22;

   function automatic logic [31:0] packElo(input logic [19:0] ppn, input logic g,
                                           input logic [1:0] mat, input logic [1:0] plv,
                                           input logic d, input logic v);
      return {4'b0, ppn, 1'b0, g, mat, plv, d, v};
   endfunction

endpackage

// File: rtl/tlb_inv_match.sv
// tlb_inv_match
//   Combinational decision whether one TLB entry is hit by an INVTLB
//   sub-operation. An invalid entry (e = 0) never matches. For 4 MB pages
//   (ps == 22) only the upper VPPN bits take part in the address compare.
//   Ports: invOp_i/invAsid_i/invVppn_i (operation), entry*_i (entry under
//   test), match_o (entry must be invalidated).

module tlb_inv_match
   import tlb_pkg::*;
(
   input  logic [4:0]  invOp_i,
   input  logic [9:0]  invAsid_i,
   input  logic [18:0] invVppn_i,
   input  logic        entryE_i,
   input  logic        entryG_i,
   input  logic [9:0]  entryAsid_i,
   input  logic [18:0] entryVppn_i,
   input  logic [5:0]  entryPs_i,
   output logic        match_o
);

   logic asidHit;
   logic vaHit;

   // Decode the sub-operation into a match on the entry's global bit,
   // ASID and virtual page number.
   always_comb begin
      asidHit = (entryAsid_i == invAsid_i);
      if (entryPs_i == PS_HUGE)
         vaHit = (entryVppn_i[18:10] == invVppn_i[18:10]);
      else
         vaHit = (entryVppn_i == invVppn_i);
      match_o = 1'b0;
      case (invOp_i)
         INV_ALL0, INV_ALL1: match_o = 1'b1;
         INV_G1:             match_o = entryG_i;
         INV_G0:             match_o = ~entryG_i;
         INV_G0_ASID:        match_o = ~entryG_i & asidHit;
         INV_G0_ASID_VA:     match_o = ~entryG_i & asidHit & vaHit;
         INV_GASID_VA:       match_o = (entryG_i | asidHit) & vaHit;
         default:            match_o = 1'b0;
      endcase
      if (!entryE_i)
         match_o = 1'b0;
   end

endmodule

// File: rtl/tlb_wb_ctrl.sv
// tlb_wb_ctrl
//   Sequencer for TLB maintenance instructions (TLBSRCH, TLBRD, TLBWR,
//   TLBFILL, INVTLB). Drives the TLB read/write ports and the CSR write-back
//   strobes/values. States: IDLE (accepts ops), EXEC (one-cycle execute,
//   op_done), SWEEP (walks every entry for INVTLB).
//   Ports: clk/reset (synchronous, active-high); op_valid/op/op_ready/
//   op_done/op_err/flush handshake; inv_* INVTLB operands; s1_found/s1_index
//   search result; csr_* current CSR values; r_* TLB read port; we/w_*
//   TLB write port; *_we/*_wv CSR write-back.
//   Parameters: TLBNUM (entries, power of two), FILL_MODE (0 round-robin,
//   1 LFSR victim).
//   Macro TLB_INVTLB_EN: enables the INVTLB sweep; without it op 5 ends
//   in EXEC with op_err.

module tlb_wb_ctrl
   import tlb_pkg::*;
#(
   parameter int TLBNUM    = 16,
   parameter int FILL_MODE = 0,
   localparam int IDXW     = $clog2(TLBNUM)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            op_valid,
   input  logic [2:0]      op,
   output logic            op_ready,
   output logic            op_done,
   output logic            op_err,
   input  logic            flush,
   input  logic [4:0]      inv_op,
   input  logic [9:0]      inv_asid,
   input  logic [18:0]     inv_vppn,
   input  logic            s1_found,
   input  logic [IDXW-1:0] s1_index,
   input  logic [31:0]     csr_tlbidx,
   input  logic [31:0]     csr_tlbehi,
   input  logic [31:0]     csr_elo0,
   input  logic [31:0]     csr_elo1,
   input  logic [31:0]     csr_asid,
   input  logic [5:0]      csr_ecode,
   output logic [IDXW-1:0] r_index,
   input  logic            r_e,
   input  logic [18:0]     r_vppn,
   input  logic [5:0]      r_ps,
   input  logic [9:0]      r_asid,
   input  logic            r_g,
   input  logic [19:0]     r_ppn0,
   input  logic [1:0]      r_plv0,
   input  logic [1:0]      r_mat0,
   input  logic            r_d0,
   input  logic            r_v0,
   input  logic [19:0]     r_ppn1,
   input  logic [1:0]      r_plv1,
   input  logic [1:0]      r_mat1,
   input  logic            r_d1,
   input  logic            r_v1,
   output logic            we,
   output logic [IDXW-1:0] w_index,
   output logic            w_e,
   output logic [18:0]     w_vppn,
   output logic [5:0]      w_ps,
   output logic [9:0]      w_asid,
   output logic            w_g,
   output logic [19:0]     w_ppn0,
   output logic [1:0]      w_plv0,
   output logic [1:0]      w_mat0,
   output logic            w_d0,
   output logic            w_v0,
   output logic [19:0]     w_ppn1,
   output logic [1:0]      w_plv1,
   output logic [1:0]      w_mat1,
   output logic            w_d1,
   output logic            w_v1,
   output logic            idx_we,
   output logic            ehi_we,
   output logic            elo_we,
   output logic            asid_we,
   output logic [31:0]     idx_wv,
   output logic [31:0]     ehi_wv,
   output logic [31:0]     elo0_wv,
   output logic [31:0]     elo1_wv,
   output logic [31:0]     asid_wv
);

   ctrlStateE       state_q, state_d;
   tlbOpE           op_q, op_d;
   logic            err_q, err_d;
   logic [IDXW-1:0] fillCnt_q, fillCnt_d;
   logic [15:0]     lfsr_q, lfsr_d;
   logic [IDXW-1:0] victim;
   logic            live;
   logic            unusedCsr;

   assign unusedCsr = ^{csr_tlbidx[30], csr_tlbehi[EHI_VPPN_LO-1:0],
                        csr_elo0[31:28], csr_elo0[7], csr_elo1[31:28], csr_elo1[7]};

   // Flush and reset both suppress every side effect in the current cycle.
   assign live   = ~flush & ~reset;
   assign victim = (FILL_MODE == 1) ? lfsr_q[IDXW-1:0] : fillCnt_q;

`ifdef TLB_INVTLB_EN
   logic [IDXW-1:0] sweepCnt_q, sweepCnt_d;
   logic [4:0]      invOp_q, invOp_d;
   logic [9:0]      invAsid_q, invAsid_d;
   logic [18:0]     invVppn_q, invVppn_d;
   logic            invMatch;

   tlb_inv_match uInvMatch (
      .invOp_i     (invOp_q),
      .invAsid_i   (invAsid_q),
      .invVppn_i   (invVppn_q),
      .entryE_i    (r_e),
      .entryG_i    (r_g),
      .entryAsid_i (r_asid),
      .entryVppn_i (r_vppn),
      .entryPs_i   (r_ps),
      .match_o     (invMatch)
   );

   // INVTLB operands are captured on accept; the sweep index restarts at
   // zero whenever the sweep is not running.
   always_comb begin
      invOp_d    = invOp_q;
      invAsid_d  = invAsid_q;
      invVppn_d  = invVppn_q;
      sweepCnt_d = (state_q == SWEEP) ? sweepCnt_q + 1'b1 : '0;
      if (state_q == IDLE && op_valid) begin
         invOp_d   = inv_op;
         invAsid_d = inv_asid;
         invVppn_d = inv_vppn;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sweepCnt_q <= '0;
         invOp_q    <= '0;
         invAsid_q  <= '0;
         invVppn_q  <= '0;
      end else begin
         sweepCnt_q <= sweepCnt_d;
         invOp_q    <= invOp_d;
         invAsid_q  <= invAsid_d;
         invVppn_q  <= invVppn_d;
      end
   end
`else
   logic unusedInv;
   assign unusedInv = ^{inv_op, inv_asid, inv_vppn};
`endif

   // Next-state logic. INVTLB with a legal sub-op sweeps the TLB, anything
   // else executes in a single EXEC cycle. Flush overrides every transition.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      err_d     = err_q;
      fillCnt_d = fillCnt_q;
      lfsr_d    = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
      case (state_q)
         IDLE: begin
            if (op_valid) begin
               op_d    = tlbOpE'(op);
               err_d   = 1'b0;
               state_d = EXEC;
               if (tlbOpE'(op) == OP_INV) begin
`ifdef TLB_INVTLB_EN
                  if (inv_op > INV_OP_MAX)
                     err_d = 1'b1;
                  else
                     state_d = SWEEP;
`else
                  err_d = 1'b1;
`endif
               end
            end
         end
         EXEC: begin
            state_d = IDLE;
            if (op_q == OP_FILL)
               fillCnt_d = fillCnt_q + 1'b1;
         end
`ifdef TLB_INVTLB_EN
         SWEEP: begin
            if (sweepCnt_q == IDXW'(TLBNUM - 1))
               state_d = EXEC;
         end
`endif
         default: state_d = IDLE;
      endcase
      if (flush) begin
         state_d   = IDLE;
         fillCnt_d = fillCnt_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         op_q      <= OP_NOP;
         err_q     <= 1'b0;
         fillCnt_q <= '0;
         lfsr_q    <= LFSR_SEED;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         err_q     <= err_d;
         fillCnt_q <= fillCnt_d;
         lfsr_q    <= lfsr_d;
      end
   end

   // Output decode. The write-port fields default to the CSR image used by
   // TLBWR/TLBFILL; a sweep instead rewrites the entry it just read with
   // e cleared.
   always_comb begin
      op_ready = (state_q == IDLE);
      op_done  = 1'b0;
      op_err   = 1'b0;
      r_index  = csr_tlbidx[IDXW-1:0];
      we       = 1'b0;
      w_index  = csr_tlbidx[IDXW-1:0];
      w_e      = (csr_ecode == ECODE_TLBR) | ~csr_tlbidx[TLBIDX_NE];
      w_vppn   = csr_tlbehi[31:EHI_VPPN_LO];
      w_ps     = csr_tlbidx[TLBIDX_PS_HI:TLBIDX_PS_LO];
      w_asid   = csr_asid[9:0];
      w_g      = csr_elo0[ELO_G] & csr_elo1[ELO_G];
      w_ppn0   = csr_elo0[ELO_PPN_HI:ELO_PPN_LO];
      w_plv0   = csr_elo0[3:2];
      w_mat0   = csr_elo0[5:4];
      w_d0     = csr_elo0[1];
      w_v0     = csr_elo0[0];
      w_ppn1   = csr_elo1[ELO_PPN_HI:ELO_PPN_LO];
      w_plv1   = csr_elo1[3:2];
      w_mat1   = csr_elo1[5:4];
      w_d1     = csr_elo1[1];
      w_v1     = csr_elo1[0];
      idx_we   = 1'b0;
      ehi_we   = 1'b0;
      elo_we   = 1'b0;
      asid_we  = 1'b0;
      idx_wv   = '0;
      ehi_wv   = '0;
      elo0_wv  = '0;
      elo1_wv  = '0;
      asid_wv  = '0;
      case (state_q)
         EXEC: begin
            if (live) begin
               op_done = 1'b1;
               op_err  = err_q;
               if (!err_q) begin
                  case (op_q)
                     OP_SRCH: begin
                        idx_we = 1'b1;
                        idx_wv = {~s1_found, 1'b0, csr_tlbidx[TLBIDX_PS_HI:TLBIDX_PS_LO],
                                  24'(s1_index)};
                     end
                     OP_RD: begin
                        idx_we  = 1'b1;
                        ehi_we  = 1'b1;
                        elo_we  = 1'b1;
                        asid_we = 1'b1;
                        if (r_e) begin
                           idx_wv  = {2'b00, r_ps, csr_tlbidx[23:0]};
                           ehi_wv  = {r_vppn, 13'b0};
                           elo0_wv = packElo(r_ppn0, r_g, r_mat0, r_plv0, r_d0, r_v0);
                           elo1_wv = packElo(r_ppn1, r_g, r_mat1, r_plv1, r_d1, r_v1);
                           asid_wv = {csr_asid[31:10], r_asid};
                        end else begin
                           idx_wv  = {2'b10, 6'b0, csr_tlbidx[23:0]};
                           asid_wv = {csr_asid[31:10], 10'b0};
                        end
                     end
                     OP_WR:   we = 1'b1;
                     OP_FILL: begin
                        we      = 1'b1;
                        w_index = victim;
                     end
                     default: ;
                  endcase
               end
            end
         end
`ifdef TLB_INVTLB_EN
         SWEEP: begin
            r_index = sweepCnt_q;
            w_index = sweepCnt_q;
            we      = live & invMatch;
            w_e     = 1'b0;
            w_vppn  = r_vppn;
            w_ps    = r_ps;
            w_asid  = r_asid;
            w_g     = r_g;
            w_ppn0  = r_ppn0;
            w_plv0  = r_plv0;
            w_mat0  = r_mat0;
            w_d0    = r_d0;
            w_v0    = r_v0;
            w_ppn1  = r_ppn1;
            w_plv1  = r_plv1;
            w_mat1  = r_mat1;
            w_d1    = r_d1;
            w_v1    = r_v1;
         end
`endif
         default: ;
      endcase
   end

endmodule
